uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
8N1-style UART transmitter, the transmit-direction companion of UART_RX. It shares the Baud8Gen strobe: Baud8Tick is a one-sys_clk pulse at 8x the baud rate, and each serial bit lasts 8 ticks (8680 ns at 115200 baud). It accepts a byte over a start/busy handshake, honours peer flow control, and shifts the frame onto TxD_ser LSB first. Parity and stop-bit count are configurable.

Parameters:
PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value is a compile-time error.
STOP_BITS, 1, number of stop bits, 1 or 2.
USE_FLOW, 1, 1 = gate frame start on synchronized RTS; 0 = ignore RTS.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
Baud8Tick  in  1  single-cycle strobe at 8x baud, from Baud8Gen.
TxD_start  in  1  request to send TxD_data; sampled only when TxD_busy=0.
TxD_data  in  8  byte to send; captured in the cycle TxD_start is accepted.
RTS  in  1  peer ready to receive; asynchronous, high = ready.
TxD_ser  out  1  serial line; idle high.
TxD_busy  out  1  high from the cycle after acceptance to the end of the last stop bit.

Behaviour:
- Reset (async assert, sync release): TxD_ser=1, TxD_busy=0, state IDLE, tick_cnt=0, bit_cnt=0, shift register=0, RTS synchronizer=0.
- Handshake:
  - Accept when TxD_start=1 and TxD_busy=0. TxD_data is latched and TxD_busy=1 on the next edge.
  - TxD_start while busy is ignored: no queueing, no effect on the current frame.
- States:
  - IDLE -> WAIT on accept.
  - WAIT: hold TxD_ser=1. Advance to START on the first Baud8Tick with rts_sync=1 (or any Baud8Tick when USE_FLOW=0). This aligns the frame to the tick grid. The RTS low time is unbounded; busy stays high.
  - START: TxD_ser=0 for 8 ticks.
  - DATA: 8 bits, LSB first, 8 ticks each.
  - PARITY: 8 ticks, present only if PARITY != 0. Even parity = XOR of the data bits; odd = its inverse.
  - STOP: TxD_ser=1 for STOP_BITS x 8 ticks, then IDLE.
- Timing:
  - All TxD_ser changes are registered and occur on the edge that samples the Baud8Tick causing the transition. The first start bit goes low 1 cycle after that tick.
  - tick_cnt (3 bits) increments only on Baud8Tick. A state or bit advances when Baud8Tick=1 and tick_cnt=7, then tick_cnt wraps to 0.
  - The cycle on which the last stop bit completes sets TxD_busy=0 on that same edge.
  - Back-to-back: a start accepted in the first idle cycle goes through WAIT. The minimum gap between the stop bit and the next start bit is therefore 1 tick period.
- Frame length: (1 + 8 + (PARITY != 0) + STOP_BITS) x 8 ticks.
- RTS:
  - Passes a 2-FF synchronizer, so there is 2 cycles of latency.
  - Checked only in WAIT. Deassertion mid-frame never truncates or pauses the frame.
- Baud8Tick is a one-cycle strobe. If it is held high for N cycles, it counts as N ticks.
- Reset mid-frame: the line returns high immediately (async), the frame is dropped, and busy=0.

Decomposition:
- uart_pkg: state enum (IDLE, WAIT, START, DATA, PARITY, STOP), PARITY encodings (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), TICKS_PER_BIT=8, DATA_BITS=8. This package is shared with UART_RX.
- One sub-module, sync_2ff: a generic 1-bit two-flop synchronizer for RTS, with async active-high reset to 0. It is reusable for RxD_ser in UART_RX.

Test Plan:
- Defaults, RTS=1, send 0x2A -> TxD_ser: 0, then bits 0,1,0,1,0,1,0,0, then 1. Each level lasts exactly 8 Baud8Tick periods. Busy is high for 80 ticks plus the alignment wait.
- Back-to-back 0x2A then 0xAB, with the second TxD_start held until busy falls -> 0xAB data bits 1,1,0,1,0,1,0,1. A stop-to-start idle gap of 1 tick period. No TxD_start is lost.
- Flow control: RTS=0 at accept, raised after 30 ticks -> line stays high and busy=1 while RTS=0. Start bit begins on the first tick at least 2 cycles after RTS rises. Dropping RTS mid-data leaves the frame intact.
- PARITY=1, STOP_BITS=2, send 0x07 -> parity bit 1, then 16 ticks high. PARITY=2 with 0x07 -> parity bit 0.
- Busy ignore: pulse TxD_start with 0xFF during a 0x2A frame -> the 0x2A waveform is unchanged and no second frame is sent.
- Reset asserted during data bit 3 -> TxD_ser=1 and TxD_busy=0 within the same cycle, asynchronously. After release, a new 0x55 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: frame state
// encoding, parity mode encodings, frame geometry and a parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Parity mode encodings
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Frame geometry: Baud8Tick strobes per serial bit, payload width
   localparam int TICKS_PER_BIT = 8;
   localparam int DATA_BITS     = 8;

   // Parity bit for a payload: even = XOR of data bits, odd = its inverse.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                       input int                   mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level into
// the clk_i domain. Output is delayed by two clk_i edges.
//   clk_i  in   destination clock
//   rst_i  in   asynchronous active-high reset, clears both flops to 0
//   d_i    in   asynchronous input level
//   q_o    out  synchronized level
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its source; blocking here would collapse
   // the two stages into one.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts a byte over a start/busy handshake, optionally
// waits for the peer's RTS, then shifts out start bit, 8 data bits (LSB
// first), an optional parity bit and 1 or 2 stop bits. Each bit lasts
// TICKS_PER_BIT Baud8Tick strobes. The serial line is registered.
//   sys_clk    in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   Baud8Tick  in   strobe at 8x baud; each high cycle counts as one tick
//   TxD_start  in   send request, honoured only while TxD_busy is low
//   TxD_data   in   byte to send, captured on acceptance
//   RTS        in   asynchronous peer-ready level (high = ready)
//   TxD_ser    out  serial line, idle high
//   TxD_busy   out  high from the cycle after acceptance to end of last stop
// Parameters:
//   PARITY     PAR_NONE / PAR_EVEN / PAR_ODD
//   STOP_BITS  1 or 2
//   USE_FLOW   1 = wait for synchronized RTS before the start bit
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1,
   parameter int USE_FLOW  = 1
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 Baud8Tick,
   input  logic                 TxD_start,
   input  logic [DATA_BITS-1:0] TxD_data,
   input  logic                 RTS,
   output logic                 TxD_ser,
   output logic                 TxD_busy
);

   // Reject unsupported configurations at elaboration time.
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] TICK_LAST = 3'(TICKS_PER_BIT - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_e          state_q,    state_d;
   logic [2:0]           tick_cnt_q, tick_cnt_d;
   logic [2:0]           bit_cnt_q,  bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic                 par_q,      par_d;
   logic                 txd_q,      txd_d;
   logic                 busy_q,     busy_d;

   logic rts_sync;
   logic rts_ok;
   logic accept;
   logic bit_done;

   sync_2ff u_rts_sync (
      .clk_i (sys_clk),
      .rst_i (rst),
      .d_i   (RTS),
      .q_o   (rts_sync)
   );

   assign rts_ok   = (USE_FLOW != 0) ? rts_sync : 1'b1;
   assign accept   = TxD_start && !busy_q;
   // Last tick of the current bit: the bit (or state) advances on this edge.
   assign bit_done = Baud8Tick && (tick_cnt_q == TICK_LAST);

   // ---------------------------------------------------------------------
   // State register (with the datapath registers it steers)
   // ---------------------------------------------------------------------
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before the case so
      // no path leaves it unassigned, which would infer a latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (accept) state_d = ST_WAIT;
         // The frame is aligned to the tick grid: it starts on a tick edge.
         ST_WAIT:   if (Baud8Tick && rts_ok) state_d = ST_START;
         ST_START:  if (bit_done) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_done && bit_cnt_q == DATA_LAST) begin
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: if (bit_done) state_d = ST_STOP;
         ST_STOP:   if (bit_done && bit_cnt_q == STOP_LAST) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Counters, shift register and captured parity
   // ---------------------------------------------------------------------
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;

      // Ticks are only counted while a bit is on the line; IDLE and WAIT keep
      // the counter parked at 0 so the start bit gets a full bit time.
      if (state_q == ST_IDLE || state_q == ST_WAIT) begin
         tick_cnt_d = '0;
      end else if (Baud8Tick) begin
         tick_cnt_d = tick_cnt_q + 3'd1;
      end

      // bit_cnt indexes data bits in DATA and stop bits in STOP.
      if (state_d != state_q) begin
         bit_cnt_d = '0;
      end else if (bit_done) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (state_q == ST_IDLE && accept) begin
         shift_d = TxD_data;
         par_d   = parity_bit(TxD_data, PARITY);
      end else if (state_q == ST_DATA && state_d == ST_DATA && bit_done) begin
         shift_d = shift_q >> 1;
      end
   end

   // ---------------------------------------------------------------------
   // Output logic: line level and busy are a function of the state being
   // entered, so they change on the very edge that advances the FSM.
   // ---------------------------------------------------------------------
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != ST_IDLE);
      unique case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = par_q;
         default:   txd_d = 1'b1;
      endcase
   end

   assign TxD_ser  = txd_q;
   assign TxD_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Drives three uart_tx configurations with a random Baud8Tick stream and
// compares the serial line, sampled once per tick, against a frame model
// built from the bit-level description of an 8N1-style frame.
//   dut0: no parity, 1 stop, flow control
//   dut1: even parity, 2 stops, flow control
//   dut2: odd parity, 1 stop, RTS ignored
// -----------------------------------------------------------------------------
module tb_uart_tx;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       tick    = 1'b0;
   logic       rts     = 1'b1;
   logic [2:0] start   = '0;
   logic [7:0] tx_data = '0;
   logic [2:0] ser;
   logic [2:0] busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Random tick stream; back-to-back high cycles count as separate ticks.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick = ($urandom_range(0, 3) == 0);
      end
   end

   uart_tx #(.PARITY(0), .STOP_BITS(1), .USE_FLOW(1)) u_dut0 (
      .sys_clk(clk), .rst(rst), .Baud8Tick(tick), .TxD_start(start[0]),
      .TxD_data(tx_data), .RTS(rts), .TxD_ser(ser[0]), .TxD_busy(busy[0]));

   uart_tx #(.PARITY(1), .STOP_BITS(2), .USE_FLOW(1)) u_dut1 (
      .sys_clk(clk), .rst(rst), .Baud8Tick(tick), .TxD_start(start[1]),
      .TxD_data(tx_data), .RTS(rts), .TxD_ser(ser[1]), .TxD_busy(busy[1]));

   uart_tx #(.PARITY(2), .STOP_BITS(1), .USE_FLOW(0)) u_dut2 (
      .sys_clk(clk), .rst(rst), .Baud8Tick(tick), .TxD_start(start[2]),
      .TxD_data(tx_data), .RTS(rts), .TxD_ser(ser[2]), .TxD_busy(busy[2]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int par_of(input int w);
      return (w == 1) ? 1 : (w == 2) ? 2 : 0;
   endfunction

   function automatic int stops_of(input int w);
      return (w == 1) ? 2 : 1;
   endfunction

   // Reference: list of bit levels for the frame, each held for 8 ticks.
   task automatic model(input int w, input logic [7:0] d,
                        output logic [127:0] lv, output int nbits);
      bit levels[$];
      int par = par_of(w);
      levels.push_back(1'b0);
      for (int i = 0; i < 8; i++) levels.push_back(d[i]);
      if (par != 0) levels.push_back((($countones(d) % 2) == 1) ^ (par == 2));
      for (int s = 0; s < stops_of(w); s++) levels.push_back(1'b1);
      lv    = '0;
      nbits = levels.size();
      foreach (levels[k]) begin
         for (int t = 0; t < 8; t++) lv = {lv[126:0], levels[k]};
      end
   endtask

   // Sample the line once per tick (on the negedge of a tick cycle, i.e. the
   // level just before the tick's edge). lead = idle samples before the
   // first start-bit sample.
   task automatic capture(input int w, input int nbits, output logic [127:0] lv,
                          output int lead, output bit busy_ok, output bit busy_fell,
                          output bit timed_out);
      int got    = 0;
      int budget = 20000;
      lv = '0; lead = 0; busy_ok = 1'b1; busy_fell = 1'b0; timed_out = 1'b0;
      while (got == 0) begin
         @(negedge clk);
         if (busy[w] !== 1'b1) busy_ok = 1'b0;
         if (tick) begin
            if (ser[w] === 1'b0) begin
               lv  = {lv[126:0], 1'b0};
               got = 1;
            end else begin
               lead++;
            end
         end
         budget--;
         if (budget == 0) begin timed_out = 1'b1; return; end
      end
      while (got < nbits * 8) begin
         @(negedge clk);
         if (busy[w] !== 1'b1) busy_ok = 1'b0;
         if (tick) begin
            lv = {lv[126:0], ser[w]};
            got++;
         end
         budget--;
         if (budget == 0) begin timed_out = 1'b1; return; end
      end
      @(negedge clk);
      busy_fell = (busy[w] === 1'b0);
   endtask

   task automatic do_frame(input int w, input logic [7:0] d, input int exp_lead,
                           input string tag, output int lead_o);
      logic [127:0] got_lv, exp_lv;
      int nb;
      bit bok, bfell, to;
      model(w, d, exp_lv, nb);
      capture(w, nb, got_lv, lead_o, bok, bfell, to);
      check({tag, ".timeout"}, to, 0);
      check({tag, ".frame"}, got_lv, exp_lv);
      if (exp_lead >= 0) check({tag, ".lead"}, lead_o, exp_lead);
      check({tag, ".busy_hi"}, bok, 1);
      check({tag, ".busy_fall"}, bfell, 1);
   endtask

   // Present a byte at a negedge; acceptance happens on the next posedge.
   task automatic send(input int w, input logic [7:0] d);
      @(negedge clk);
      check($sformatf("send%0d.idle", w), busy[w], 0);
      tx_data  = d;
      start[w] = 1'b1;
      @(posedge clk);
      #1;
      start[w] = 1'b0;
      check($sformatf("send%0d.busy", w), busy[w], 1);
   endtask

   initial begin
      int lead, exp_lead, t1, cnt, budget;
      bit saw;
      logic [7:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         check($sformatf("reset%0d.ser", w), ser[w], 1);
         check($sformatf("reset%0d.busy", w), busy[w], 0);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Basic 0x2A frame
      send(0, 8'h2A);
      do_frame(0, 8'h2A, 1, "basic_2a", lead);

      // Back-to-back: second start raised mid-frame and held until accepted
      send(0, 8'h2A);
      fork
         do_frame(0, 8'h2A, 1, "b2b_first", lead);
         begin
            repeat (40) @(negedge clk);
            tx_data  = 8'hAB;
            start[0] = 1'b1;
         end
      join
      fork
         do_frame(0, 8'hAB, 1, "b2b_second", lead);
         begin
            @(posedge clk);
            #1;
            start[0] = 1'b0;
            check("b2b.accept", busy[0], 1);
         end
      join

      // Start pulse while busy is ignored
      send(0, 8'h2A);
      fork
         do_frame(0, 8'h2A, 1, "ignore", lead);
         begin
            repeat (30) @(negedge clk);
            tx_data  = 8'hFF;
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
         end
      join
      saw = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (busy[0] !== 1'b0 || ser[0] !== 1'b1) saw = 1'b1;
      end
      check("ignore.no_second", saw, 0);

      // Flow control: RTS low at accept, raised after 30 ticks, dropped mid-data
      rts = 1'b0;
      repeat (4) @(negedge clk);
      send(0, 8'h2A);
      exp_lead = 0;
      fork
         do_frame(0, 8'h2A, -1, "flow", lead);
         begin
            cnt = 0;
            while (cnt < 30) begin
               @(negedge clk);
               if (tick) cnt++;
            end
            rts = 1'b1;
            @(negedge clk);
            t1 = int'(tick);
            // Ticks up to RTS rise, one too early for the synchronizer, and
            // the tick that launches the start bit all sample an idle line.
            exp_lead = 30 + t1 + 1;
            cnt = 0;
            while (cnt < 20) begin
               @(negedge clk);
               if (tick) cnt++;
            end
            rts = 1'b0;
         end
      join
      check("flow.lead", lead, exp_lead);
      rts = 1'b1;
      repeat (4) @(negedge clk);

      // Parity variants
      send(1, 8'h07);
      do_frame(1, 8'h07, 1, "par_even_2stop", lead);
      rts = 1'b0;
      send(2, 8'h07);
      do_frame(2, 8'h07, 1, "par_odd_noflow", lead);
      rts = 1'b1;
      repeat (4) @(negedge clk);

      // Random bytes across all configurations
      for (int i = 0; i < 9; i++) begin
         d = 8'($urandom);
         send(i % 3, d);
         do_frame(i % 3, d, 1, $sformatf("rand%0d_dut%0d", i, i % 3), lead);
      end

      // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line is low)
      send(0, 8'hC3);
      cnt = 0;
      budget = 5000;
      while (cnt < 37 && budget > 0) begin
         @(negedge clk);
         if (tick) cnt++;
         budget--;
      end
      check("rst_mid.reach", cnt, 37);
      check("rst_mid.pre_bit3", ser[0], 0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid.ser", ser[0], 1);
      check("rst_mid.busy", busy[0], 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send(0, 8'h55);
      do_frame(0, 8'h55, 1, "after_rst_55", lead);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
